// File: rtl/fp_mul_exp_pipe.sv
// FP multiplier exponent/sign datapath: two stall-capable stages,
// overflow/underflow/zero classification and saturating event counters.
module fp_mul_exp_pipe #(
  parameter int EXP_W = 8,
  parameter int BIAS  = 127,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] a_exp,
  input  logic [EXP_W-1:0] b_exp,
  input  logic             a_s,
  input  logic             b_s,
  input  logic             norm_inc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] c_exp,
  output logic             c_s,
  output logic             c_ovf,
  output logic             c_unf,
  output logic             c_zero,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic [CNT_W-1:0] unf_cnt
);

  localparam int RW = EXP_W + 2;
  localparam logic [RW-1:0] LP_BIAS = RW'(BIAS);
  localparam logic [RW-1:0] LP_MAX  = {2'b00, {EXP_W{1'b1}}};

  logic             w_en1;
  logic             w_en2;
  logic             w_out_xfer;
  logic [RW-1:0]    w_raw;
  logic             w_z;
  logic             w_inf;

  logic             r_s1_v;
  logic [RW-1:0]    r_raw;
  logic             r_s;
  logic             r_z;
  logic             r_inf;

  logic             r_s2_v;
  logic [EXP_W-1:0] r_c_exp;
  logic             r_c_s;
  logic             r_c_ovf;
  logic             r_c_unf;
  logic             r_c_zero;

  logic [EXP_W-1:0] w_exp_n;
  logic             w_ovf_n;
  logic             w_unf_n;
  logic             w_zero_n;
  logic             w_raw_neg;
  logic             w_raw_le0;
  logic             w_raw_big;

  logic [CNT_W-1:0] r_ovf_cnt;
  logic [CNT_W-1:0] r_unf_cnt;

  // out_ready reaches in_ready combinationally through both enables
  assign w_en2      = !r_s2_v | out_ready;
  assign w_en1      = !r_s1_v | w_en2;
  assign in_ready   = w_en1;
  assign w_out_xfer = r_s2_v & out_ready;

  assign w_raw = {2'b00, a_exp}
               + {2'b00, b_exp}
               + {{(RW-1){1'b0}}, norm_inc}
               - LP_BIAS;
  assign w_z   = (a_exp == '0) | (b_exp == '0);
  assign w_inf = (&a_exp) | (&b_exp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_v <= 1'b0;
      r_raw  <= '0;
      r_s    <= 1'b0;
      r_z    <= 1'b0;
      r_inf  <= 1'b0;
    end else if (w_en1) begin
      r_s1_v <= in_valid;
      if (in_valid) begin
        r_raw <= w_raw;
        r_s   <= a_s ^ b_s;
        r_z   <= w_z;
        r_inf <= w_inf;
      end
    end
  end

  assign w_raw_neg = r_raw[RW-1];
  assign w_raw_le0 = w_raw_neg | (r_raw == '0);
  assign w_raw_big = !w_raw_neg & (r_raw >= LP_MAX);

  // zero beats overflow beats underflow
  always_comb begin
    w_exp_n  = r_raw[EXP_W-1:0];
    w_ovf_n  = 1'b0;
    w_unf_n  = 1'b0;
    w_zero_n = 1'b0;
    if (r_z) begin
      w_zero_n = 1'b1;
      w_exp_n  = '0;
    end else if (r_inf | w_raw_big) begin
      w_ovf_n  = 1'b1;
      w_exp_n  = '1;
    end else if (w_raw_le0) begin
      w_unf_n  = 1'b1;
      w_exp_n  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_v   <= 1'b0;
      r_c_exp  <= '0;
      r_c_s    <= 1'b0;
      r_c_ovf  <= 1'b0;
      r_c_unf  <= 1'b0;
      r_c_zero <= 1'b0;
    end else if (w_en2) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_c_exp  <= w_exp_n;
        r_c_s    <= r_s;
        r_c_ovf  <= w_ovf_n;
        r_c_unf  <= w_unf_n;
        r_c_zero <= w_zero_n;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf_cnt <= '0;
      r_unf_cnt <= '0;
    end else if (cnt_clr) begin
      r_ovf_cnt <= '0;
      r_unf_cnt <= '0;
    end else if (w_out_xfer) begin
      if (r_c_ovf && (r_ovf_cnt != '1))
        r_ovf_cnt <= r_ovf_cnt + 1'b1;
      if (r_c_unf && (r_unf_cnt != '1))
        r_unf_cnt <= r_unf_cnt + 1'b1;
    end
  end

  assign out_valid = r_s2_v;
  assign c_exp     = r_c_exp;
  assign c_s       = r_c_s;
  assign c_ovf     = r_c_ovf;
  assign c_unf     = r_c_unf;
  assign c_zero    = r_c_zero;
  assign ovf_cnt   = r_ovf_cnt;
  assign unf_cnt   = r_unf_cnt;

endmodule

// File: tb/tb_fp_mul_exp_pipe.sv
// Bench for fp_mul_exp_pipe: directed table, stall/reset sequences,
// counter saturation and a randomized scoreboard run.
module tb_fp_mul_exp_pipe;

  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0;
  logic        in_ready;
  logic [7:0]  a_exp = 0;
  logic [7:0]  b_exp = 0;
  logic        a_s = 0;
  logic        b_s = 0;
  logic        norm_inc = 0;
  logic        out_valid;
  logic        out_ready = 1;
  logic [7:0]  c_exp;
  logic        c_s;
  logic        c_ovf;
  logic        c_unf;
  logic        c_zero;
  logic        cnt_clr = 0;
  logic [15:0] ovf_cnt;
  logic [15:0] unf_cnt;

  int total = 0;
  int bad = 0;

  fp_mul_exp_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_exp(a_exp), .b_exp(b_exp),
    .a_s(a_s), .b_s(b_s), .norm_inc(norm_inc),
    .out_valid(out_valid), .out_ready(out_ready),
    .c_exp(c_exp), .c_s(c_s),
    .c_ovf(c_ovf), .c_unf(c_unf), .c_zero(c_zero),
    .cnt_clr(cnt_clr),
    .ovf_cnt(ovf_cnt), .unf_cnt(unf_cnt)
  );

  always #5 clk = ~clk;

  wire [11:0] got = {c_s, c_ovf, c_unf, c_zero, c_exp};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // result word {sign, ovf, unf, zero, exp} from plain integer arithmetic
  function automatic logic [11:0] model(input int a, input int b,
                                        input logic sa, input logic sb,
                                        input logic ni);
    int raw;
    logic s;
    raw = a + b + int'(ni) - 127;
    s = sa ^ sb;
    if (a == 0 || b == 0) return {s, 3'b001, 8'h00};
    if (a == 255 || b == 255 || raw >= 255) return {s, 3'b100, 8'hFF};
    if (raw <= 0) return {s, 3'b010, 8'h00};
    return {s, 3'b000, raw[7:0]};
  endfunction

  logic [11:0] q[$];
  int          m_ovf = 0;
  int          m_unf = 0;
  logic        have_hold = 0;
  logic [11:0] hold;

  // scoreboard: predicts transfers at the coming rising edge
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_ovf = 0;
      m_unf = 0;
      have_hold = 0;
    end else begin
      chk("ovf_cnt", ovf_cnt, m_ovf);
      chk("unf_cnt", unf_cnt, m_unf);
      if (out_valid) begin
        if (have_hold) chk("stall_hold", got, hold);
        if (out_ready) begin
          have_hold = 0;
          if (q.size() == 0) begin
            chk("unexpected_out", 1, 0);
          end else begin
            chk("stream", got, q.pop_front());
          end
          if (!cnt_clr) begin
            if (c_ovf && m_ovf != 16'hFFFF) m_ovf++;
            if (c_unf && m_unf != 16'hFFFF) m_unf++;
          end
        end else begin
          hold = got;
          have_hold = 1;
        end
      end else begin
        have_hold = 0;
      end
      if (cnt_clr) begin
        m_ovf = 0;
        m_unf = 0;
      end
      if (in_valid && in_ready)
        q.push_back(model(a_exp, b_exp, a_s, b_s, norm_inc));
    end
  end

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sa;
    logic        sb;
    logic        ni;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[11];

  task automatic drive(input logic [7:0] a, input logic [7:0] b,
                       input logic sa, input logic sb, input logic ni);
    a_exp = a; b_exp = b; a_s = sa; b_s = sb; norm_inc = ni;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    @(posedge clk); #1;
    drive(v.a, v.b, v.sa, v.sb, v.ni);
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_valid"}, out_valid, 1);
    chk(nm, got, v.exp);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (n < 40) begin
      @(posedge clk); #2;
      if (q.size() == 0 && !out_valid) break;
      n++;
    end
    if (n >= 40) chk("drain_timeout", 1, 0);
  endtask

  initial begin
    tbl[0]  = '{8'h80, 8'h81, 1, 0, 0, {1'b1, 3'b000, 8'h82}};
    tbl[1]  = '{8'hFE, 8'h7F, 0, 0, 0, {1'b0, 3'b000, 8'hFE}};
    tbl[2]  = '{8'hFE, 8'h7F, 0, 0, 1, {1'b0, 3'b100, 8'hFF}};
    tbl[3]  = '{8'h01, 8'h01, 0, 0, 0, {1'b0, 3'b010, 8'h00}};
    tbl[4]  = '{8'h00, 8'hFF, 0, 0, 0, {1'b0, 3'b001, 8'h00}};
    tbl[5]  = '{8'h7E, 8'h01, 0, 1, 1, {1'b1, 3'b000, 8'h01}};
    tbl[6]  = '{8'h7E, 8'h01, 0, 0, 0, {1'b0, 3'b010, 8'h00}};
    tbl[7]  = '{8'hFF, 8'h01, 1, 1, 0, {1'b0, 3'b100, 8'hFF}};
    tbl[8]  = '{8'h00, 8'hFF, 1, 0, 1, {1'b1, 3'b001, 8'h00}};
    tbl[9]  = '{8'hC0, 8'hC0, 0, 1, 0, {1'b1, 3'b100, 8'hFF}};
    tbl[10] = '{8'h7F, 8'h7F, 1, 1, 1, {1'b0, 3'b000, 8'h80}};

    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_outs", got, 0);
    chk("rst_cnts", {ovf_cnt, unf_cnt}, 0);
    @(posedge clk); #1;
    rst = 0;

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));
    drain();

    // three offers against a blocked output
    @(posedge clk); #1;
    out_ready = 0;
    drive(8'h80, 8'h80, 0, 0, 0);
    in_valid = 1;
    @(negedge clk);
    chk("stall_rdy0", in_ready, 1);
    @(posedge clk); #1;
    drive(8'h90, 8'h01, 0, 1, 0);
    @(negedge clk);
    chk("stall_rdy1", in_ready, 1);
    @(posedge clk); #1;
    drive(8'h01, 8'h02, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_rdy2", in_ready, 0);
      chk("stall_first", got, model(8'h80, 8'h80, 0, 0, 0));
      @(posedge clk); #1;
    end
    out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("release_valid", out_valid, 1);
      @(posedge clk); #1;
      in_valid = 0;
    end
    drain();

    // ovf counter saturation
    @(posedge clk); #1;
    cnt_clr = 1;
    @(posedge clk); #1;
    cnt_clr = 0;
    drive(8'hFF, 8'h01, 0, 0, 0);
    in_valid = 1;
    repeat (65535) @(posedge clk);
    #1;
    in_valid = 0;
    drain();
    chk("ovf_sat", ovf_cnt, 16'hFFFF);
    run_vec(tbl[2], "ovf_more");
    drain();
    chk("ovf_hold", ovf_cnt, 16'hFFFF);
    @(posedge clk); #1;
    drive(8'hFE, 8'h7F, 0, 0, 1);
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    chk("clr_pre_valid", out_valid, 1);
    cnt_clr = 1;
    @(posedge clk); #1;
    cnt_clr = 0;
    chk("clr_wins", ovf_cnt, 0);
    drain();

    // randomized traffic with backpressure
    for (int i = 0; i < 400; i++) begin
      logic [7:0] pick[8];
      pick[0] = 8'h00; pick[1] = 8'h01; pick[2] = 8'h7E;
      pick[3] = 8'h7F; pick[4] = 8'h80; pick[5] = 8'hFE;
      pick[6] = 8'hFF; pick[7] = 8'($urandom);
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a_exp = ($urandom_range(0, 1) != 0) ? 8'($urandom)
                                          : pick[$urandom_range(0, 7)];
      b_exp = ($urandom_range(0, 1) != 0) ? 8'($urandom)
                                          : pick[$urandom_range(0, 7)];
      a_s = 1'($urandom);
      b_s = 1'($urandom);
      norm_inc = 1'($urandom);
      cnt_clr = ($urandom_range(0, 63) == 0);
    end
    @(posedge clk); #1;
    in_valid = 0;
    cnt_clr = 0;
    out_ready = 1;
    drain();

    // reset with both stages full
    drive(8'hFE, 8'h7F, 0, 0, 1);
    in_valid = 1;
    @(posedge clk); #1;
    drive(8'h01, 8'h01, 0, 0, 0);
    @(posedge clk); #1;
    in_valid = 0;
    out_ready = 0;
    drive(8'hFF, 8'h80, 0, 0, 0);
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    out_ready = 0;
    @(posedge clk); #1;
    chk("full_valid", out_valid, 1);
    chk("full_ready", in_ready, 0);
    chk("full_cnt", ovf_cnt != 0, 1);
    rst = 1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_cnts", {ovf_cnt, unf_cnt}, 0);
    @(posedge clk); #1;
    rst = 0;
    out_ready = 1;
    run_vec(tbl[0], "post_rst");
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
